// File: rtl/shift_buffer_pkg.sv
// Shared encodings for the multi-mode word shift buffer.
package shift_buffer_pkg;

    // Operating mode, sampled from the mode input while idle.
    typedef enum logic [1:0] {
        ModeSiso = 2'b00,
        ModeSipo = 2'b01,
        ModePiso = 2'b10,
        ModeRsvd = 2'b11
    } mode_e;

    // Controller state.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSiso  = 3'd1,
        StFill  = 3'd2,
        StHold  = 3'd3,
        StDrain = 3'd4
    } state_e;

endpackage

// File: rtl/shift_buffer_if.sv
// Handshake bundle for the shift buffer: serial in/out, parallel in/out, mode and status.
interface shift_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [1:0]              mode;
    logic                    clear;
    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_W-1:0]       s_data;
    logic                    p_in_valid;
    logic                    p_in_ready;
    logic [DATA_W*DEPTH-1:0] p_in_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [DATA_W-1:0]       m_data;
    logic                    p_out_valid;
    logic                    p_out_ready;
    logic [DATA_W*DEPTH-1:0] p_out_data;
    logic [CNT_W-1:0]        count;
    logic                    busy;

    modport slave (
        input  mode, clear, s_valid, s_data, p_in_valid, p_in_data, m_ready, p_out_ready,
        output s_ready, p_in_ready, m_valid, m_data, p_out_valid, p_out_data, count, busy
    );

    modport master (
        output mode, clear, s_valid, s_data, p_in_valid, p_in_data, m_ready, p_out_ready,
        input  s_ready, p_in_ready, m_valid, m_data, p_out_valid, p_out_data, count, busy
    );
endinterface

// File: rtl/shift_buffer_ctrl.sv
// Shift buffer controller: FSM, mode latch, occupancy count, handshake decode and
// storage strobes.
import shift_buffer_pkg::*;

module shift_buffer_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic             s_valid,
    input  logic             p_in_valid,
    input  logic             m_ready,
    input  logic             p_out_ready,
    output logic             s_ready,
    output logic             p_in_ready,
    output logic             m_valid,
    output logic             p_out_valid,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             push,
    output logic             load
);
    localparam logic [CNT_W-1:0] Full = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] One  = CNT_W'(1);

    state_e           state_q;
    mode_e            cur_mode_q;
    logic [CNT_W-1:0] count_q;
    // Readies stay low from reset until the first clock edge after release.
    logic             rst_done_q;
    logic             s_ready_raw;
    logic             p_in_ready_raw;
    logic             pop;
    logic             p_out_fire;

    // Handshake decode: readies from state/count/mode/m_ready, valids from state/count only.
    always_comb begin
        s_ready_raw    = 1'b0;
        p_in_ready_raw = 1'b0;
        m_valid        = 1'b0;
        p_out_valid    = 1'b0;
        unique case (state_q)
            StIdle: begin
                unique case (mode_e'(mode))
                    ModeSiso, ModeSipo: s_ready_raw    = 1'b1;
                    ModePiso:           p_in_ready_raw = 1'b1;
                    default:            ;
                endcase
            end
            StSiso: begin
                m_valid     = (count_q == Full);
                s_ready_raw = (cur_mode_q == ModeSiso) & ((count_q < Full) | m_ready);
            end
            StFill:  s_ready_raw = (cur_mode_q == ModeSipo);
            StHold:  p_out_valid = 1'b1;
            StDrain: m_valid     = (count_q != '0);
            default: ;
        endcase
    end

    assign s_ready    = s_ready_raw & rst_done_q;
    assign p_in_ready = p_in_ready_raw & rst_done_q;
    assign count      = count_q;
    assign busy       = (state_q != StIdle);

    // clear suppresses every fire in the same cycle.
    assign push       = s_valid & s_ready & ~clear;
    assign load       = p_in_valid & p_in_ready & ~clear;
    assign pop        = m_valid & m_ready & ~clear;
    assign p_out_fire = p_out_valid & p_out_ready & ~clear;

    // State, mode latch and occupancy update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_mode_q <= ModeSiso;
            count_q    <= '0;
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            if (state_q == StIdle) begin
                cur_mode_q <= mode_e'(mode);
            end
            if (clear) begin
                state_q <= StIdle;
                count_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (push) begin
                            count_q <= One;
                            state_q <= (mode_e'(mode) == ModeSiso) ? StSiso : StFill;
                        end else if (load) begin
                            count_q <= Full;
                            state_q <= StDrain;
                        end
                    end
                    StSiso: begin
                        if (push && !pop) begin
                            count_q <= count_q + One;
                        end else if (pop && !push) begin
                            count_q <= count_q - One;
                            if (count_q == One) begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StFill: begin
                        if (push) begin
                            count_q <= count_q + One;
                            if (count_q == Full - One) begin
                                state_q <= StHold;
                            end
                        end
                    end
                    StHold: begin
                        if (p_out_fire) begin
                            count_q <= '0;
                            state_q <= StIdle;
                        end
                    end
                    StDrain: begin
                        if (pop) begin
                            count_q <= count_q - One;
                            if (count_q == One) begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_buffer.sv
// Multi-mode word shift buffer: storage array and output muxes around the controller.
import shift_buffer_pkg::*;

module shift_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    shift_buffer_if.slave  bus
);
    logic [DATA_W-1:0] elem_q [DEPTH];
    logic              push;
    logic              load;
    logic              m_valid;
    logic              p_out_valid;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  rd_idx;

    shift_buffer_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .mode        (bus.mode),
        .clear       (bus.clear),
        .s_valid     (bus.s_valid),
        .p_in_valid  (bus.p_in_valid),
        .m_ready     (bus.m_ready),
        .p_out_ready (bus.p_out_ready),
        .s_ready     (bus.s_ready),
        .p_in_ready  (bus.p_in_ready),
        .m_valid     (m_valid),
        .p_out_valid (p_out_valid),
        .count       (count),
        .busy        (bus.busy),
        .push        (push),
        .load        (load)
    );

    assign bus.m_valid     = m_valid;
    assign bus.p_out_valid = p_out_valid;
    assign bus.count       = count;

    // Storage: frame load places word 0 at the oldest slot; push shifts toward higher index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                elem_q[i] <= '0;
            end
        end else if (load) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                elem_q[DEPTH-1-i] <= bus.p_in_data[i*DATA_W +: DATA_W];
            end
        end else if (push) begin
            elem_q[0] <= bus.s_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                elem_q[i] <= elem_q[i-1];
            end
        end
    end

    // Serial output: oldest word at elem[count-1], zero when not valid.
    always_comb begin
        rd_idx     = count - CNT_W'(1);
        bus.m_data = '0;
        if (m_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rd_idx == CNT_W'(i)) begin
                    bus.m_data = elem_q[i];
                end
            end
        end
    end

    // Parallel output: slice 0 is the first word received, zero when not valid.
    always_comb begin
        bus.p_out_data = '0;
        if (p_out_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bus.p_out_data[i*DATA_W +: DATA_W] = elem_q[DEPTH-1-i];
            end
        end
    end

endmodule

// File: tb/tb_shift_buffer.sv
// Directed scoreboard bench for shift_buffer (DATA_W=8, DEPTH=4).
module tb_shift_buffer;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic clk;
    logic rst;

    shift_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    shift_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [DATA_W-1:0]       exp_words  [$];
    logic [DATA_W*DEPTH-1:0] exp_frames [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every accepted serial word and frame against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            if (exp_words.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_m_word: got 0x%0h, want no word", bus.m_data);
            end else begin
                check("sb_m_word", 64'(bus.m_data), 64'(exp_words.pop_front()));
            end
        end
        if (!rst && bus.p_out_valid && bus.p_out_ready) begin
            if (exp_frames.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_frame: got 0x%0h, want no frame", bus.p_out_data);
            end else begin
                check("sb_frame", 64'(bus.p_out_data), 64'(exp_frames.pop_front()));
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] piso_w [4];
        piso_w = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        rst             = 1'b1;
        bus.mode        = 2'b00;
        bus.clear       = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.p_in_valid  = 1'b0;
        bus.p_in_data   = '0;
        bus.m_ready     = 1'b0;
        bus.p_out_ready = 1'b0;

        // Reset: every output low, including readies.
        #2;
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_p_in_ready", 64'(bus.p_in_ready), 64'd0);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 64'(bus.s_ready), 64'd0);
        tick();
        check("idle_siso_s_ready", 64'(bus.s_ready), 64'd1);

        // SISO delay line.
        foreach (piso_w[k]) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'h11 * 8'(k + 1);
            tick();
        end
        bus.s_valid = 1'b0;
        check("siso_count", 64'(bus.count), 64'd4);
        check("siso_m_valid", 64'(bus.m_valid), 64'd1);
        check("siso_m_data", 64'(bus.m_data), 64'h11);
        check("siso_full_s_ready", 64'(bus.s_ready), 64'd0);
        exp_words.push_back(8'h11);
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        #1;
        check("siso_pass_s_ready", 64'(bus.s_ready), 64'd1);
        tick();
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        check("siso_count_after", 64'(bus.count), 64'd4);
        check("siso_m_data_next", 64'(bus.m_data), 64'h22);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("siso_clear_busy", 64'(bus.busy), 64'd0);

        // SIPO frame assembly with back-pressure.
        bus.mode = 2'b01;
        for (int k = 0; k < 4; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'hA0 + 8'(k);
            tick();
        end
        bus.s_valid = 1'b0;
        check("sipo_p_out_valid", 64'(bus.p_out_valid), 64'd1);
        check("sipo_s_ready", 64'(bus.s_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            check("sipo_hold_data", 64'(bus.p_out_data), 64'hA3A2A1A0);
            tick();
        end
        exp_frames.push_back(32'hA3A2A1A0);
        bus.p_out_ready = 1'b1;
        tick();
        bus.p_out_ready = 1'b0;
        check("sipo_done_count", 64'(bus.count), 64'd0);
        check("sipo_done_busy", 64'(bus.busy), 64'd0);

        // PISO serialisation with m_ready toggling.
        bus.mode       = 2'b10;
        bus.p_in_valid = 1'b1;
        bus.p_in_data  = 32'hDDCCBBAA;
        #1;
        check("piso_p_in_ready", 64'(bus.p_in_ready), 64'd1);
        tick();
        bus.p_in_valid = 1'b0;
        foreach (piso_w[k]) exp_words.push_back(piso_w[k]);
        for (int k = 0; k < 4; k++) begin
            bus.m_ready = 1'b0;
            check("piso_m_data", 64'(bus.m_data), 64'(piso_w[k]));
            check("piso_busy_ready", 64'(bus.p_in_ready), 64'd0);
            tick();
            check("piso_m_data_held", 64'(bus.m_data), 64'(piso_w[k]));
            bus.m_ready = 1'b1;
            tick();
        end
        bus.m_ready = 1'b0;
        check("piso_idle_p_in_ready", 64'(bus.p_in_ready), 64'd1);
        check("piso_idle_busy", 64'(bus.busy), 64'd0);

        // Mode change mid-FILL is ignored until back in idle.
        bus.mode = 2'b01;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) bus.mode = 2'b10;
            bus.s_valid = 1'b1;
            bus.s_data  = 8'hB0 + 8'(k);
            #1;
            check("modechg_s_ready", 64'(bus.s_ready), 64'd1);
            check("modechg_p_in_ready", 64'(bus.p_in_ready), 64'd0);
            tick();
        end
        bus.s_valid = 1'b0;
        check("modechg_frame", 64'(bus.p_out_data), 64'hB3B2B1B0);
        exp_frames.push_back(32'hB3B2B1B0);
        bus.p_out_ready = 1'b1;
        tick();
        bus.p_out_ready = 1'b0;
        check("modechg_idle_p_in_ready", 64'(bus.p_in_ready), 64'd1);
        check("modechg_idle_s_ready", 64'(bus.s_ready), 64'd0);

        // clear wins over a push at count 3.
        bus.mode = 2'b01;
        for (int k = 0; k < 3; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'hC0 + 8'(k);
            tick();
        end
        check("clr_pre_count", 64'(bus.count), 64'd3);
        bus.s_data = 8'hC3;
        bus.clear  = 1'b1;
        tick();
        bus.clear   = 1'b0;
        bus.s_valid = 1'b0;
        check("clr_count", 64'(bus.count), 64'd0);
        check("clr_busy", 64'(bus.busy), 64'd0);
        tick();
        check("clr_no_frame", 64'(bus.p_out_valid), 64'd0);

        // rst during DRAIN.
        bus.mode       = 2'b10;
        bus.p_in_valid = 1'b1;
        bus.p_in_data  = 32'h44332211;
        tick();
        bus.p_in_valid = 1'b0;
        check("drain_m_data", 64'(bus.m_data), 64'h11);
        rst = 1'b1;
        #1;
        check("midrst_m_valid", 64'(bus.m_valid), 64'd0);
        check("midrst_m_data", 64'(bus.m_data), 64'd0);
        check("midrst_count", 64'(bus.count), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_p_in_ready", 64'(bus.p_in_ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reserved mode: nothing accepted.
        bus.mode       = 2'b11;
        bus.s_valid    = 1'b1;
        bus.p_in_valid = 1'b1;
        #1;
        check("rsvd_s_ready", 64'(bus.s_ready), 64'd0);
        check("rsvd_p_in_ready", 64'(bus.p_in_ready), 64'd0);
        tick();
        check("rsvd_count", 64'(bus.count), 64'd0);
        check("rsvd_busy", 64'(bus.busy), 64'd0);
        bus.s_valid    = 1'b0;
        bus.p_in_valid = 1'b0;

        tick();
        check("sb_words_left", 64'(exp_words.size()), 64'd0);
        check("sb_frames_left", 64'(exp_frames.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
